scroll_disp_ctrl: RTL

SCROLL_DISP_CTRL -- requirements
Module: scroll_disp_ctrl

---
 rtl/scroll_disp_if.sv | 35 +++
 rtl/scroll_disp_ctrl.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/scroll_disp_if.sv
// Bus bundle for scroll_disp_ctrl: buffer write port, scroll control and display outputs.
// Strobes (wr_en, start, stop) act on the rising edge where they are high; no backpressure.
interface scroll_disp_if #(
  parameter int DIGITS  = 4,
  parameter int MSG_MAX = 16
);
  localparam int AW = $clog2(MSG_MAX);
  localparam int LW = AW + 1;
  localparam int PW = $clog2(MSG_MAX + DIGITS) + 1;

  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [4:0]        wr_char;
  logic [LW-1:0]     msg_len;
  logic              start;
  logic              stop;
  logic              dir;
  logic              pause;
  logic [4:0]        disp_code;
  logic [DIGITS-1:0] en;
  logic              busy;
  logic              wrap;
  logic [1:0]        dbg_state;
  logic [PW-1:0]     dbg_pos;

  modport master (
    output wr_en, wr_addr, wr_char, msg_len, start, stop, dir, pause,
    input  disp_code, en, busy, wrap, dbg_state, dbg_pos
  );

  modport slave (
    input  wr_en, wr_addr, wr_char, msg_len, start, stop, dir, pause,
    output disp_code, en, busy, wrap, dbg_state, dbg_pos
  );
endinterface

// File: rtl/scroll_disp_ctrl.sv
// Scrolling message controller for a multiplexed 7-segment display.
// Optional macro SCROLL_PAUSE_BLINK_EN: blink the display while paused.
module scroll_disp_ctrl #(
  parameter int DIGITS     = 4,
  parameter int MSG_MAX    = 16,
  parameter int SCROLL_DIV = 100
) (
  input logic          slow_clk1,
  input logic          rst,
  scroll_disp_if.slave bus
);
  localparam int AW = $clog2(MSG_MAX);
  localparam int LW = AW + 1;
  localparam int PW = $clog2(MSG_MAX + DIGITS) + 1;
  localparam int CW = $clog2(SCROLL_DIV);
  localparam int SW = $clog2(DIGITS);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_e;

  state_e            state_q, state_d;
  logic [PW-1:0]     pos_q, pos_d;
  logic [LW-1:0]     len_q, len_d;
  logic              dir_q, dir_d;
  logic [CW-1:0]     presc_q, presc_d;
  logic [SW-1:0]     sidx_q, sidx_d;
  logic [DIGITS-1:0] en_q, en_d;
  logic [4:0]        code_q, code_d;
  logic              wrap_q, wrap_d;
  logic [4:0]        buf_q [MSG_MAX];
  logic [4:0]        buf_d [MSG_MAX];
`ifdef SCROLL_PAUSE_BLINK_EN
  logic [CW-1:0]     blink_cnt_q, blink_cnt_d;
  logic              blink_lit_q, blink_lit_d;
`endif

  logic [LW-1:0]     len_in;
  logic [PW-1:0]     end_pos;
  logic [PW-1:0]     idx;
  logic [4:0]        cur_char;

  // Message lengths beyond the buffer depth are clamped so indexing stays in range.
  assign len_in  = (bus.msg_len > LW'(MSG_MAX)) ? LW'(MSG_MAX) : bus.msg_len;
  assign end_pos = PW'(len_q) + PW'(DIGITS);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    len_d   = len_q;
    dir_d   = dir_q;
    presc_d = presc_q;
    wrap_d  = 1'b0;
    buf_d   = buf_q;
    if (state_q == IDLE && bus.wr_en) buf_d[bus.wr_addr] = bus.wr_char;
    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop && bus.msg_len != '0) begin
          state_d = RUN;
          len_d   = len_in;
          dir_d   = bus.dir;
          pos_d   = bus.dir ? (PW'(len_in) + PW'(DIGITS)) : '0;
          presc_d = '0;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_d = IDLE;
        end else begin
          if (bus.pause) state_d = PAUSE;
          if (presc_q == CW'(SCROLL_DIV - 1)) begin
            presc_d = '0;
            // At the far end the window jumps back to its start position.
            if (dir_q ? (pos_q == '0) : (pos_q == end_pos)) begin
              pos_d  = dir_q ? end_pos : '0;
              wrap_d = 1'b1;
            end else begin
              pos_d = dir_q ? (pos_q - PW'(1)) : (pos_q + PW'(1));
            end
          end else begin
            presc_d = presc_q + CW'(1);
          end
        end
      end
      PAUSE: begin
        if (bus.stop)        state_d = IDLE;
        else if (!bus.pause) state_d = RUN;
      end
      default: state_d = IDLE;
    endcase
  end

  // Digit k shows buffer[pos-1-k]; positions outside the message are blank.
  always_comb begin
    sidx_d   = (sidx_q == SW'(DIGITS - 1)) ? '0 : sidx_q + SW'(1);
    idx      = pos_q - PW'(sidx_q) - PW'(1);
    cur_char = '0;
    if (pos_q > PW'(sidx_q) && idx < PW'(len_q)) cur_char = buf_q[idx[AW-1:0]];
    en_d   = '1;
    code_d = '0;
    if (state_q != IDLE) begin
      en_d   = ~(DIGITS'(1) << sidx_q);
      code_d = cur_char;
    end
`ifdef SCROLL_PAUSE_BLINK_EN
    blink_cnt_d = '0;
    blink_lit_d = 1'b0;
    if (state_q == PAUSE) begin
      blink_lit_d = blink_lit_q;
      if (blink_cnt_q == CW'(SCROLL_DIV - 1)) begin
        blink_cnt_d = '0;
        blink_lit_d = ~blink_lit_q;
      end else begin
        blink_cnt_d = blink_cnt_q + CW'(1);
      end
      if (!blink_lit_q) en_d = '1;
    end
`endif
  end

  always_ff @(posedge slow_clk1 or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pos_q   <= '0;
      len_q   <= '0;
      dir_q   <= 1'b0;
      presc_q <= '0;
      sidx_q  <= '0;
      en_q    <= '1;
      code_q  <= '0;
      wrap_q  <= 1'b0;
      for (int i = 0; i < MSG_MAX; i++) buf_q[i] <= '0;
`ifdef SCROLL_PAUSE_BLINK_EN
      blink_cnt_q <= '0;
      blink_lit_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      pos_q   <= pos_d;
      len_q   <= len_d;
      dir_q   <= dir_d;
      presc_q <= presc_d;
      sidx_q  <= sidx_d;
      en_q    <= en_d;
      code_q  <= code_d;
      wrap_q  <= wrap_d;
      buf_q   <= buf_d;
`ifdef SCROLL_PAUSE_BLINK_EN
      blink_cnt_q <= blink_cnt_d;
      blink_lit_q <= blink_lit_d;
`endif
    end
  end

  assign bus.disp_code = code_q;
  assign bus.en        = en_q;
  assign bus.busy      = (state_q != IDLE);
  assign bus.wrap      = wrap_q;
  assign bus.dbg_state = state_q;
  assign bus.dbg_pos   = pos_q;
endmodule
